second_tick_gen: RTL and testbench

- Time-base and set-button front end that drives the seconds counter.
- Divides the system clock into a one-cycle seconds enable pulse (en_s).
- Debounces the raw up/down set buttons and issues set pulses: one on press, then auto-repeat while the button is held.
- Drives the seconds counter's en_s, up and down inputs directly.

---
 rtl/second_tick_gen.sv | 193 +++++++++++++++++++
 tb/tb_second_tick_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/second_tick_gen.sv
// Seconds time base plus debounced up/down set buttons with press pulse and auto-repeat.
// Drives en_s/up/down of the seconds counter; all outputs are registered.
module second_tick_gen #(
  parameter int CLK_DIV         = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic en_s,
  output logic up,
  output logic down,
  output logic set_active
);

  localparam int DIV_W  = (CLK_DIV > 1)         ? $clog2(CLK_DIV)         : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int RPT_W  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP_HOLD = 3'd1,
    UP_RPT  = 3'd2,
    DN_HOLD = 3'd3,
    DN_RPT  = 3'd4
  } state_t;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0] raw;
  logic [1:0] deb;
  logic [1:0] rise;

  assign raw = {btn_down_raw, btn_up_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             s1_reg;
      logic             s2_reg;
      logic             deb_reg;
      logic             deb_d_reg;
      logic [DEB_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= raw[gi];
          s2_reg    <= s1_reg;
          deb_d_reg <= deb_reg;
          if (s2_reg != deb_reg) begin
            if (cnt_reg == DEB_LAST) begin
              deb_reg <= s2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + DEB_W'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign deb[gi]  = deb_reg;
      assign rise[gi] = deb_reg & ~deb_d_reg;
    end
  endgenerate

  state_t              state_reg, state_next;
  logic                set_pulse;
  logic                tick;
  logic [DIV_W-1:0]    presc_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [RPT_W-1:0]    rpt_cnt_reg;
  logic                en_s_next, up_next, down_next, set_active_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      en_s       <= 1'b0;
      up         <= 1'b1;
      down       <= 1'b0;
      set_active <= 1'b0;
    end else begin
      state_reg  <= state_next;
      en_s       <= en_s_next;
      up         <= up_next;
      down       <= down_next;
      set_active <= set_active_next;
    end
  end

  // Exit has priority over a repeat pulse; a press while the other button is high is ignored.
  always_comb begin
    state_next = state_reg;
    set_pulse  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise[0] && !deb[1]) begin
          state_next = UP_HOLD;
          set_pulse  = 1'b1;
        end else if (rise[1] && !deb[0]) begin
          state_next = DN_HOLD;
          set_pulse  = 1'b1;
        end
      end
      UP_HOLD: begin
        if (!deb[0] || rise[1]) begin
          state_next = IDLE;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = UP_RPT;
          set_pulse  = 1'b1;
        end
      end
      UP_RPT: begin
        if (!deb[0] || rise[1]) begin
          state_next = IDLE;
        end else if (rpt_cnt_reg == RPT_LAST) begin
          set_pulse = 1'b1;
        end
      end
      DN_HOLD: begin
        if (!deb[1] || rise[0]) begin
          state_next = IDLE;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = DN_RPT;
          set_pulse  = 1'b1;
        end
      end
      DN_RPT: begin
        if (!deb[1] || rise[0]) begin
          state_next = IDLE;
        end else if (rpt_cnt_reg == RPT_LAST) begin
          set_pulse = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A normal tick only fires when the FSM stays in IDLE, so a coinciding press wins.
  assign tick = (state_reg == IDLE) && (state_next == IDLE) && run && (presc_reg == DIV_LAST);

  always_comb begin
    en_s_next       = set_pulse | tick;
    up_next         = !((state_next == DN_HOLD) || (state_next == DN_RPT));
    down_next       = (state_next == DN_HOLD) || (state_next == DN_RPT);
    set_active_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg    <= '0;
      hold_cnt_reg <= '0;
      rpt_cnt_reg  <= '0;
    end else begin
      if ((state_reg != IDLE) || (state_next != IDLE) || !run) begin
        presc_reg <= '0;
      end else if (presc_reg == DIV_LAST) begin
        presc_reg <= '0;
      end else begin
        presc_reg <= presc_reg + DIV_W'(1);
      end

      if (((state_reg == UP_HOLD) || (state_reg == DN_HOLD)) && (state_next == state_reg)) begin
        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
      end else begin
        hold_cnt_reg <= '0;
      end

      if (((state_reg == UP_RPT) || (state_reg == DN_RPT)) && (state_next == state_reg)) begin
        rpt_cnt_reg <= (rpt_cnt_reg == RPT_LAST) ? '0 : rpt_cnt_reg + RPT_W'(1);
      end else begin
        rpt_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_second_tick_gen.sv
// Directed plus randomized bench for second_tick_gen, checked every cycle against a
// time-elapsed reference model of the tick/set behaviour.
module tb_second_tick_gen;

  localparam int CD = 10;
  localparam int DB = 4;
  localparam int HC = 20;
  localparam int RC = 5;

  logic clk = 1'b0;
  logic rst, run, btn_up_raw, btn_down_raw;
  logic en_s, up, down, set_active;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;

  second_tick_gen #(
    .CLK_DIV(CD), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
    .en_s(en_s), .up(up), .down(down), .set_active(set_active)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = setting up, 2 = setting down.
  int m_s1[2], m_s2[2], m_deb[2], m_deb_prev[2], m_diff[2];
  int m_mode, m_elapsed, m_idle_cnt;
  logic m_en, m_up, m_down, m_set;

  task automatic model_step(input logic r, input logic run_i, input logic bu, input logic bd);
    int rise[2];
    int raw_v[2];
    int own, other;
    raw_v[0] = int'(bu);
    raw_v[1] = int'(bd);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_deb_prev[i] = 0; m_diff[i] = 0;
      end
      m_mode = 0; m_elapsed = 0; m_idle_cnt = 0;
      m_en = 1'b0; m_up = 1'b1; m_down = 1'b0; m_set = 1'b0;
      return;
    end
    for (int i = 0; i < 2; i++) rise[i] = (m_deb[i] == 1 && m_deb_prev[i] == 0) ? 1 : 0;
    m_en = 1'b0;
    if (m_mode == 0) begin
      if (rise[0] == 1 && m_deb[1] == 0) begin
        m_mode = 1; m_elapsed = 0; m_en = 1'b1; m_idle_cnt = 0;
      end else if (rise[1] == 1 && m_deb[0] == 0) begin
        m_mode = 2; m_elapsed = 0; m_en = 1'b1; m_idle_cnt = 0;
      end else if (run_i) begin
        m_idle_cnt++;
        if (m_idle_cnt == CD) begin
          m_en = 1'b1;
          m_idle_cnt = 0;
        end
      end else begin
        m_idle_cnt = 0;
      end
    end else begin
      own = (m_mode == 1) ? 0 : 1;
      other = 1 - own;
      if (m_deb[own] == 0 || rise[other] == 1) begin
        m_mode = 0; m_idle_cnt = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed >= HC && ((m_elapsed - HC) % RC) == 0) m_en = 1'b1;
      end
    end
    m_up = (m_mode != 2);
    m_down = (m_mode == 2);
    m_set = (m_mode != 0);
    for (int i = 0; i < 2; i++) begin
      m_deb_prev[i] = m_deb[i];
      if (m_s2[i] != m_deb[i]) begin
        m_diff[i]++;
        if (m_diff[i] == DB) begin
          m_deb[i] = m_s2[i];
          m_diff[i] = 0;
        end
      end else begin
        m_diff[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw_v[i];
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic step(input logic r, input logic run_i, input logic bu, input logic bd);
    rst = r; run = run_i; btn_up_raw = bu; btn_down_raw = bd;
    @(posedge clk);
    model_step(r, run_i, bu, bd);
    cyc++;
    @(negedge clk);
    chk("en_s", en_s, m_en);
    chk("up", up, m_up);
    chk("down", down, m_down);
    chk("set_active", set_active, m_set);
    if (en_s === 1'b1) pulse_cnt++;
  endtask

  task automatic hold(input int n, input logic r, input logic run_i, input logic bu, input logic bd);
    for (int k = 0; k < n; k++) step(r, run_i, bu, bd);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; btn_up_raw = 1'b0; btn_down_raw = 1'b0;

    // Reset, then free-running ticks.
    hold(2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_up", up, 1'b1);
    chk("reset_en_s", en_s, 1'b0);
    pulse_cnt = 0;
    hold(100, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    assert (pulse_cnt == 10)
    else begin
      errors++;
      $error("FAIL t1_pulse_count observed=%0d expected=10", pulse_cnt);
    end
    $display("step 1: free run, %0d pulses in 100 cycles", pulse_cnt);

    // Pause and resume.
    hold(50, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(30, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("step 2: pause 50 cycles then resume");

    // Short glitch, long up hold with repeats, release.
    hold(3, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(20, 1'b0, 1'b1, 1'b0, 1'b0);
    hold(60, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(30, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("step 3: up glitch then 60-cycle hold");

    // Down hold.
    hold(30, 1'b0, 1'b1, 1'b0, 1'b1);
    hold(30, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("step 4: down 30-cycle hold");

    // Simultaneous press, then down pressed during up repeat.
    hold(30, 1'b0, 1'b1, 1'b1, 1'b1);
    hold(20, 1'b0, 1'b1, 1'b0, 1'b0);
    hold(40, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b1, 1'b1, 1'b1);
    hold(30, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("step 5: simultaneous press and cross press");

    // Reset in the middle of up repeat.
    hold(33, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_mid_set_active", set_active, 1'b0);
    chk("rst_mid_en_s", en_s, 1'b0);
    hold(30, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(20, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("step 6: reset during repeat");

    // Randomized segments.
    for (int s = 0; s < 250; s++) begin
      int dur;
      logic r_run, r_up, r_dn;
      dur   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 60));
      r_run = ($urandom_range(0, 3) != 0);
      r_up  = ($urandom_range(0, 2) == 0);
      r_dn  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) step(1'b1, r_run, r_up, r_dn);
      hold(dur, 1'b0, r_run, r_up, r_dn);
      $display("seg %0d: run=%0b up=%0b down=%0b cycles=%0d", s, r_run, r_up, r_dn, dur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
